control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  input  1  single system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 EXEC  input  1  start request, level-sampled only in timestep T0.
REQ-004 INSTR  input  10  instruction word; [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored.
REQ-005 IR  output  10  registered instruction register.
REQ-006 TIME  output  2  current timestep (0=T0 .. 3=T3); feeds the timestep display.
REQ-007 DONE  output  1  high during the final timestep of every instruction; feeds the done LED.
REQ-008 EXT_EN  output  1  drive external data (INSTR as data word) onto BUS.
REQ-009 RIN  output  4  one-hot register-file write enable, index = target register.
REQ-010 ROUT  output  4  one-hot register-file bus-drive enable.
REQ-011 AIN  output  1  load ALU operand register A from BUS.
REQ-012 GIN  output  1  load ALU result register G.
REQ-013 GOUT  output  1  drive G onto BUS.
REQ-014 ALU_OP  output  2  00 add (A+BUS), 01 sub (A-BUS), 10 invert (~BUS), 11 bit-reverse (BUS[0:9]).

Function
REQ-015 TIME SHALL be a 2-bit state register; all control outputs SHALL be decoded combinationally from TIME and IR only (Moore).
REQ-016 In T0 all of EXT_EN, RIN, ROUT, AIN, GIN, GOUT, DONE SHALL be 0.
REQ-017 In T0, on a rising edge with EXEC=1: IR <= INSTR and TIME <= 1; with EXEC=0: IR and TIME hold.
REQ-018 Outside T0, EXEC and INSTR SHALL be ignored and IR SHALL hold.
REQ-019 LOAD (0000): T1 EXT_EN, RIN[Rx], DONE.
REQ-020 COPY (0001): T1 ROUT[Ry], RIN[Rx], DONE.
REQ-021 ADD (0010) / SUB (0011): T1 ROUT[Rx], AIN; T2 ROUT[Ry], GIN, ALU_OP=00/01; T3 GOUT, RIN[Rx], DONE.
REQ-022 INV (0100) / FLP (0101): T1 ROUT[Ry], GIN, ALU_OP=10/11; T2 GOUT, RIN[Rx], DONE.
REQ-023 ADDI (0110) / SUBI (0111): T1 ROUT[Rx], AIN; T2 EXT_EN, GIN, ALU_OP=00/01; T3 GOUT, RIN[Rx], DONE.
REQ-024 Opcodes 1xxx are illegal: T1 DONE only, all enables 0, no register written.
REQ-025 On the rising edge ending a timestep with DONE=1, TIME SHALL return to 0; otherwise TIME SHALL increment by 1.
REQ-026 TIME SHALL never wrap 3->0 except via DONE; no instruction exceeds T3.
REQ-027 At most one of EXT_EN, GOUT, ROUT bits SHALL be high in any cycle; RIN and ROUT SHALL each be one-hot or zero.
REQ-028 ALU_OP SHALL be 00 in every cycle where GIN=0.
REQ-029 Rx=Ry SHALL be legal and execute the normal sequence (e.g. ADD R1,R1 doubles R1).
REQ-030 EXEC held high continuously SHALL start a new instruction on the edge after each return to T0; minimum T0 dwell is one cycle.

Reset
REQ-031 Reset=1 SHALL immediately force TIME=0 and IR=0, and all control outputs and DONE SHALL drop to 0 without waiting for a clock edge.
REQ-032 Reset asserted mid-instruction SHALL abandon it; no RIN pulse for that instruction SHALL occur after Reset rises.
REQ-033 After Reset deasserts, the block SHALL wait in T0 for EXEC.

Verification
REQ-034 LOAD: INSTR=0000_10_00_00, EXEC pulse -> T1: EXT_EN=1, RIN=0100, DONE=1; next edge TIME=0.
REQ-035 ADD: INSTR=0010_01_10_00 -> T1 ROUT=0010 AIN; T2 ROUT=0100 GIN ALU_OP=00; T3 GOUT RIN=0010 DONE; TIME sequence 0,1,2,3,0.
REQ-036 FLP R3<-rev(R0): INSTR=0101_11_00_00 -> T1 ROUT=0001 GIN ALU_OP=11; T2 GOUT RIN=1000 DONE.
REQ-037 Illegal: INSTR=1010_00_00_00 -> T1 DONE=1, all enables 0; TIME back to 0 after one cycle.
REQ-038 Reset during T2 of SUBI -> outputs 0 and TIME=0 same cycle, IR=0, no RIN pulse; EXEC with LOAD afterwards executes normally.
REQ-039 EXEC held 1 with INSTR changed during T1..T3 -> IR unchanged until T0; back-to-back COPY instructions show TIME 0,1,0,1 and the bus-exclusivity check holds every cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// Four-timestep control sequencer for a small bus-based processor datapath.
// Latches an instruction on EXEC in T0 and steps through its bus/enable schedule.
module control_sequencer (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_exec,
    input  logic [9:0] i_instr,
    output logic [9:0] o_ir,
    output logic [1:0] o_time,
    output logic       o_done,
    output logic       o_ext_en,
    output logic [3:0] o_rin,
    output logic [3:0] o_rout,
    output logic       o_ain,
    output logic       o_gin,
    output logic       o_gout,
    output logic [1:0] o_alu_op
);

    localparam int unsigned IR_W  = 10;
    localparam int unsigned REG_N = 4;
    localparam int unsigned OP_W  = 2;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } time_t;

    localparam logic [3:0] OPC_LOAD = 4'b0000;
    localparam logic [3:0] OPC_COPY = 4'b0001;
    localparam logic [3:0] OPC_ADD  = 4'b0010;
    localparam logic [3:0] OPC_SUB  = 4'b0011;
    localparam logic [3:0] OPC_INV  = 4'b0100;
    localparam logic [3:0] OPC_FLP  = 4'b0101;
    localparam logic [3:0] OPC_ADDI = 4'b0110;
    localparam logic [3:0] OPC_SUBI = 4'b0111;

    localparam logic [OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [OP_W-1:0] ALU_INV = 2'b10;
    localparam logic [OP_W-1:0] ALU_REV = 2'b11;

    time_t              r_time;
    logic [IR_W-1:0]    r_ir;
    logic               r_done;
    logic               r_ext_en;
    logic [REG_N-1:0]   r_rin;
    logic [REG_N-1:0]   r_rout;
    logic               r_ain;
    logic               r_gin;
    logic               r_gout;
    logic [OP_W-1:0]    r_alu_op;

    time_t              w_next_time;
    logic [IR_W-1:0]    w_next_ir;
    logic               w_done;
    logic               w_ext_en;
    logic [REG_N-1:0]   w_rin;
    logic [REG_N-1:0]   w_rout;
    logic               w_ain;
    logic               w_gin;
    logic               w_gout;
    logic [OP_W-1:0]    w_alu_op;
    logic [3:0]         w_opc;
    logic [REG_N-1:0]   w_rx_oh;
    logic [REG_N-1:0]   w_ry_oh;

    // Timestep/IR advance: latch only in T0, leave the sequence only via DONE.
    always_comb begin
        w_next_time = r_time;
        w_next_ir   = r_ir;
        if (r_time == T0) begin
            if (i_exec) begin
                w_next_time = T1;
                w_next_ir   = i_instr;
            end
        end else if (r_done) begin
            w_next_time = T0;
        end else begin
            w_next_time = time_t'(2'(r_time + 2'd1));
        end
    end

    // Moore decode of the upcoming (timestep, IR) pair; registered below so the
    // enables are aligned with TIME/IR and cleared together by reset.
    always_comb begin
        w_done   = 1'b0;
        w_ext_en = 1'b0;
        w_rin    = '0;
        w_rout   = '0;
        w_ain    = 1'b0;
        w_gin    = 1'b0;
        w_gout   = 1'b0;
        w_alu_op = ALU_ADD;
        w_opc    = w_next_ir[9:6];
        w_rx_oh  = 4'(4'b0001 << w_next_ir[5:4]);
        w_ry_oh  = 4'(4'b0001 << w_next_ir[3:2]);

        case (w_next_time)
            T1: begin
                case (w_opc)
                    OPC_LOAD: begin
                        w_ext_en = 1'b1;
                        w_rin    = w_rx_oh;
                        w_done   = 1'b1;
                    end
                    OPC_COPY: begin
                        w_rout = w_ry_oh;
                        w_rin  = w_rx_oh;
                        w_done = 1'b1;
                    end
                    OPC_ADD, OPC_SUB, OPC_ADDI, OPC_SUBI: begin
                        w_rout = w_rx_oh;
                        w_ain  = 1'b1;
                    end
                    OPC_INV: begin
                        w_rout   = w_ry_oh;
                        w_gin    = 1'b1;
                        w_alu_op = ALU_INV;
                    end
                    OPC_FLP: begin
                        w_rout   = w_ry_oh;
                        w_gin    = 1'b1;
                        w_alu_op = ALU_REV;
                    end
                    default: begin
                        // Illegal opcode: finish immediately with no side effects.
                        w_done = 1'b1;
                    end
                endcase
            end
            T2: begin
                case (w_opc)
                    OPC_ADD, OPC_SUB: begin
                        w_rout   = w_ry_oh;
                        w_gin    = 1'b1;
                        w_alu_op = (w_opc == OPC_SUB) ? ALU_SUB : ALU_ADD;
                    end
                    OPC_ADDI, OPC_SUBI: begin
                        w_ext_en = 1'b1;
                        w_gin    = 1'b1;
                        w_alu_op = (w_opc == OPC_SUBI) ? ALU_SUB : ALU_ADD;
                    end
                    OPC_INV, OPC_FLP: begin
                        w_gout = 1'b1;
                        w_rin  = w_rx_oh;
                        w_done = 1'b1;
                    end
                    default: begin
                        w_done = 1'b1;
                    end
                endcase
            end
            T3: begin
                w_gout = 1'b1;
                w_rin  = w_rx_oh;
                w_done = 1'b1;
            end
            default: begin
                w_done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_time   <= T0;
            r_ir     <= '0;
            r_done   <= 1'b0;
            r_ext_en <= 1'b0;
            r_rin    <= '0;
            r_rout   <= '0;
            r_ain    <= 1'b0;
            r_gin    <= 1'b0;
            r_gout   <= 1'b0;
            r_alu_op <= '0;
        end else begin
            r_time   <= w_next_time;
            r_ir     <= w_next_ir;
            r_done   <= w_done;
            r_ext_en <= w_ext_en;
            r_rin    <= w_rin;
            r_rout   <= w_rout;
            r_ain    <= w_ain;
            r_gin    <= w_gin;
            r_gout   <= w_gout;
            r_alu_op <= w_alu_op;
        end
    end

    assign o_ir     = r_ir;
    assign o_time   = r_time;
    assign o_done   = r_done;
    assign o_ext_en = r_ext_en;
    assign o_rin    = r_rin;
    assign o_rout   = r_rout;
    assign o_ain    = r_ain;
    assign o_gin    = r_gin;
    assign o_gout   = r_gout;
    assign o_alu_op = r_alu_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-timestep control vectors plus
// continuous bus-exclusivity / ALU_OP invariants.
module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic       exec;
    logic [9:0] instr;
    logic [9:0] ir;
    logic [1:0] tm;
    logic       done;
    logic       ext_en;
    logic [3:0] rin;
    logic [3:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [1:0] alu_op;

    int checks   = 0;
    int failures = 0;
    bit inv_on   = 1'b0;

    control_sequencer dut (
        .i_clock  (clk),
        .i_reset  (rst),
        .i_exec   (exec),
        .i_instr  (instr),
        .o_ir     (ir),
        .o_time   (tm),
        .o_done   (done),
        .o_ext_en (ext_en),
        .o_rin    (rin),
        .o_rout   (rout),
        .o_ain    (ain),
        .o_gin    (gin),
        .o_gout   (gout),
        .o_alu_op (alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector layout: {ext_en, rin, rout, ain, gin, gout, done, alu_op}
    function automatic logic [14:0] cv(input logic e, input logic [3:0] ri, input logic [3:0] ro,
                                       input logic a, input logic gi, input logic go,
                                       input logic d, input logic [1:0] op);
        return {e, ri, ro, a, gi, go, d, op};
    endfunction

    function automatic logic [14:0] obs();
        return {ext_en, rin, rout, ain, gin, gout, done, alu_op};
    endfunction

    task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Invariants checked every cycle once the bench is running.
    always @(negedge clk) begin
        if (inv_on) begin
            checks++;
            assert ($countones({ext_en, gout, rout}) <= 1) else begin
                failures++;
                $error("FAIL bus_excl observed=%b expected=onehot0", {ext_en, gout, rout});
            end
            checks++;
            assert ($countones(rin) <= 1) else begin
                failures++;
                $error("FAIL rin_onehot observed=%b expected=onehot0", rin);
            end
            checks++;
            assert (gin || alu_op === 2'b00) else begin
                failures++;
                $error("FAIL aluop_idle observed=%b expected=00", alu_op);
            end
        end
    end

    localparam logic [14:0] Z = 15'd0;

    initial begin
        rst   = 1'b1;
        exec  = 1'b0;
        instr = 10'd0;
        #1;
        chk("rst_time", 15'(tm), 15'd0);
        chk("rst_ir",   15'(ir), 15'd0);
        chk("rst_ctrl", obs(), Z);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        inv_on = 1'b1;
        step();
        chk("idle_time", 15'(tm), 15'd0);

        // LOAD R2
        instr = 10'b0000_10_00_00; exec = 1'b1;
        step(); exec = 1'b0;
        chk("load_t1_time", 15'(tm), 15'd1);
        chk("load_t1", obs(), cv(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        chk("load_ir", 15'(ir), 15'(10'b0000_10_00_00));
        step();
        chk("load_t0_time", 15'(tm), 15'd0);
        chk("load_t0", obs(), Z);

        // ADD R1,R2
        instr = 10'b0010_01_10_00; exec = 1'b1;
        step(); exec = 1'b0;
        chk("add_t1_time", 15'(tm), 15'd1);
        chk("add_t1", obs(), cv(1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
        step();
        chk("add_t2_time", 15'(tm), 15'd2);
        chk("add_t2", obs(), cv(1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
        step();
        chk("add_t3_time", 15'(tm), 15'd3);
        chk("add_t3", obs(), cv(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00));
        step();
        chk("add_t0_time", 15'(tm), 15'd0);

        // FLP R3 <- rev(R0)
        instr = 10'b0101_11_00_00; exec = 1'b1;
        step(); exec = 1'b0;
        chk("flp_t1", obs(), cv(1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11));
        step();
        chk("flp_t2", obs(), cv(1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00));
        step();
        chk("flp_t0_time", 15'(tm), 15'd0);

        // INV R0 <- ~R1
        instr = 10'b0100_00_01_00; exec = 1'b1;
        step(); exec = 1'b0;
        chk("inv_t1", obs(), cv(1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10));
        step();
        chk("inv_t2", obs(), cv(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00));
        step();

        // Illegal opcode
        instr = 10'b1010_00_00_00; exec = 1'b1;
        step(); exec = 1'b0;
        chk("ill_t1_time", 15'(tm), 15'd1);
        chk("ill_t1", obs(), cv(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        step();
        chk("ill_t0_time", 15'(tm), 15'd0);

        // SUB R3,R3 (Rx == Ry)
        instr = 10'b0011_11_11_00; exec = 1'b1;
        step(); exec = 1'b0;
        chk("sub_t1", obs(), cv(1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
        step();
        chk("sub_t2", obs(), cv(1'b0, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01));
        step();
        chk("sub_t3", obs(), cv(1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00));
        step();

        // SUBI R1 interrupted by reset in T2
        instr = 10'b0111_01_10_00; exec = 1'b1;
        step(); exec = 1'b0;
        chk("subi_t1", obs(), cv(1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
        step();
        chk("subi_t2", obs(), cv(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", obs(), Z);
        chk("mid_rst_time", 15'(tm), 15'd0);
        chk("mid_rst_ir",   15'(ir), 15'd0);
        @(negedge clk);
        chk("rst_hold_ctrl", obs(), Z);
        rst = 1'b0;
        step();
        chk("post_rst_rin", 15'(rin), 15'd0);
        chk("post_rst_time", 15'(tm), 15'd0);

        instr = 10'b0000_01_00_00; exec = 1'b1;
        step(); exec = 1'b0;
        chk("post_load_t1", obs(), cv(1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        step();

        // EXEC held high; INSTR changes after the latch must not reach IR
        instr = 10'b0010_00_01_00; exec = 1'b1;
        step();
        instr = 10'b1111_11_11_00;
        chk("hold_t1_ir", 15'(ir), 15'(10'b0010_00_01_00));
        step();
        chk("hold_t2_ir", 15'(ir), 15'(10'b0010_00_01_00));
        chk("hold_t2", obs(), cv(1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
        step();
        chk("hold_t3_ir", 15'(ir), 15'(10'b0010_00_01_00));
        chk("hold_t3", obs(), cv(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00));

        // Back-to-back COPY with EXEC held
        instr = 10'b0001_10_11_00;
        step();
        chk("b2b_a_t0_time", 15'(tm), 15'd0);
        step();
        chk("b2b_a_t1_time", 15'(tm), 15'd1);
        chk("b2b_a_t1", obs(), cv(1'b0, 4'b0100, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        instr = 10'b0001_01_00_00;
        step();
        chk("b2b_b_t0_time", 15'(tm), 15'd0);
        chk("b2b_b_t0_ir", 15'(ir), 15'(10'b0001_10_11_00));
        step();
        chk("b2b_b_t1_time", 15'(tm), 15'd1);
        chk("b2b_b_t1", obs(), cv(1'b0, 4'b0010, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        exec = 1'b0;
        step();
        step();
        chk("final_idle_time", 15'(tm), 15'd0);
        inv_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
